// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side buffer between the UART receiver and the host. Each completed
// receiver word (rising edge of the word-ready flag) is pushed, with its
// framing-error tag, into a small circular FIFO. The host reads through a
// show-ahead port. FIFO fullness is fed back to the receiver as host-not-ready.
//
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN
//   defined   : framing tag stored per entry, rd_err reflects the head word.
//   undefined : no tag storage, rd_err = 0, words with Error2 = 1 are discarded.
//
// Ports
//   Sample_clk          receiver sample clock, all state on rising edge
//   rst_b               asynchronous reset, active-high
//   Rx_datareg          receiver data word
//   read_not_ready_out  receiver word-ready flag (level, high while word held)
//   Error1              receiver host-not-ready error, sets overrun
//   Error2              receiver framing error for the current word
//   read_not_ready_in   to receiver, equals full
//   rd_en               host pop request
//   rd_data / rd_err    head entry and its framing tag (0 while empty)
//   empty / full        FIFO status
//   count               stored entries, 0..depth
//   overrun             sticky lost-word flag
//   clr_overrun         clears overrun (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int word_size  = 8,
    parameter int depth_log2 = 2
) (
    input  logic                  Sample_clk,
    input  logic                  rst_b,
    input  logic [word_size-1:0]  Rx_datareg,
    input  logic                  read_not_ready_out,
    input  logic                  Error1,
    input  logic                  Error2,
    output logic                  read_not_ready_in,
    input  logic                  rd_en,
    output logic [word_size-1:0]  rd_data,
    output logic                  rd_err,
    output logic                  empty,
    output logic                  full,
    output logic [depth_log2:0]   count,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int DEPTH = 1 << depth_log2;

    logic                  rdy_q;
    logic                  capture;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [word_size-1:0]  mem [DEPTH];

    // One capture per word regardless of how long the flag stays high.
    assign capture = read_not_ready_out & ~rdy_q;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign push_req = capture;
`else
    // Errored words are silently discarded when no tag storage exists.
    assign push_req = capture & ~Error2;
`endif

    // count never exceeds DEPTH, so its MSB alone marks the full state.
    assign full              = count[depth_log2];
    assign empty             = (count == '0);
    assign read_not_ready_in = full;

    assign pop  = rd_en & ~empty;
    // A pop on the same edge frees the slot being written into.
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_ff @(posedge Sample_clk or posedge rst_b) begin
        if (rst_b) begin
            rdy_q   <= 1'b1;  // flag already high at release is not captured
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            rdy_q <= read_not_ready_out;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop | Error1)    overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge Sample_clk) begin
        if (push) mem[wr_ptr] <= Rx_datareg;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic tag [DEPTH];

    always_ff @(posedge Sample_clk) begin
        if (push) tag[wr_ptr] <= Error2;
    end

    assign rd_err = empty ? 1'b0 : tag[rd_ptr];
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// checked against a queue-based reference model by a negedge monitor.
module tb_uart_rx_fifo;

    localparam int W     = 8;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   rx_data = '0;
    logic           flag = 1'b0;
    logic           e1 = 1'b0;
    logic           e2 = 1'b0;
    logic           rd_en = 1'b0;
    logic           clr = 1'b0;
    logic           rnr_in;
    logic [W-1:0]   rd_data;
    logic           rd_err;
    logic           empty;
    logic           full;
    logic [DL2:0]   count;
    logic           overrun;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.word_size(W), .depth_log2(DL2)) dut (
        .Sample_clk        (clk),
        .rst_b             (rst),
        .Rx_datareg        (rx_data),
        .read_not_ready_out(flag),
        .Error1            (e1),
        .Error2            (e2),
        .read_not_ready_in (rnr_in),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_err            (rd_err),
        .empty             (empty),
        .full              (full),
        .count             (count),
        .overrun           (overrun),
        .clr_overrun       (clr)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents as {err, data} entries.
    logic [W:0] exp_q[$];
    bit         m_prev = 1'b1;
    bit         m_ovr  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_prev = 1'b1;
                m_ovr  = 1'b0;
            end else begin
                bit cap, acc, popped, lost;
                cap    = flag && !m_prev;
                m_prev = flag;
                acc    = cap && (TAG_EN || !e2);
                popped = rd_en && exp_q.size() > 0;
                if (popped) void'(exp_q.pop_front());
                lost = 1'b0;
                if (acc) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({TAG_EN ? e2 : 1'b0, rx_data});
                    else                      lost = 1'b1;
                end
                if (lost || e1) m_ovr = 1'b1;
                else if (clr)   m_ovr = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable at negedge; compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("count",   32'(count),   32'(exp_q.size()));
                chk("empty",   32'(empty),   32'(exp_q.size() == 0));
                chk("full",    32'(full),    32'(exp_q.size() == DEPTH));
                chk("rnr_in",  32'(rnr_in),  32'(exp_q.size() == DEPTH));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                if (exp_q.size() > 0) begin
                    chk("rd_data", 32'(rd_data), 32'(exp_q[0][W-1:0]));
                    chk("rd_err",  32'(rd_err),  32'(exp_q[0][W]));
                end
            end
        end
    end

    task automatic cyc(input bit f, input logic [W-1:0] d, input bit er1, input bit er2,
                       input bit rd, input bit cl);
        @(negedge clk);
        #1;
        flag = f; rx_data = d; e1 = er1; e2 = er2; rd_en = rd; clr = cl;
    endtask

    task automatic word(input logic [W-1:0] d, input bit er2);
        cyc(1, d, 0, er2, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic settle;
        @(negedge clk);
        #2;
    endtask

    initial begin
        // Reset released with the word-ready flag already high.
        flag = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        cyc(1, 8'hEE, 0, 0, 0, 0);
        cyc(1, 8'hEE, 0, 0, 0, 0);
        settle();
        chk("rst_flag_high_count", 32'(count), 32'd0);
        chk("rst_flag_high_empty", 32'(empty), 32'd1);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Two words, then two pops.
        word(8'hA5, 0);
        word(8'h3C, 0);
        settle();
        chk("two_words_head", 32'(rd_data), 32'hA5);
        pops(2);
        settle();
        chk("two_words_empty", 32'(empty), 32'd1);
        chk("two_words_ovr",   32'(overrun), 32'd0);

        // Five words with no pops: fifth is lost.
        for (int i = 1; i <= 5; i++) word(8'(i), 0);
        settle();
        chk("fill_full",    32'(full),    32'd1);
        chk("fill_rnr",     32'(rnr_in),  32'd1);
        chk("fill_overrun", 32'(overrun), 32'd1);
        chk("fill_head",    32'(rd_data), 32'h01);
        pops(4);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Full FIFO with capture and pop on the same edge.
        for (int i = 0; i < 4; i++) word(8'h10 + 8'(i), 0);
        cyc(1, 8'h99, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        settle();
        chk("simul_count", 32'(count),   32'd4);
        chk("simul_ovr",   32'(overrun), 32'd0);
        pops(3);
        settle();
        chk("simul_4th", 32'(rd_data), 32'h99);
        pops(1);

        // Framing-errored word.
        word(8'h55, 1);
        settle();
        if (TAG_EN) begin
            chk("err_word_data", 32'(rd_data), 32'h55);
            chk("err_word_tag",  32'(rd_err),  32'd1);
        end else begin
            chk("err_word_count", 32'(count), 32'd0);
        end
        pops(1);

        // Error1 with clr_overrun: set wins; clr alone then clears.
        cyc(0, 8'h00, 1, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);
        settle();
        chk("e1_clr_ovr", 32'(overrun), 32'd1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);
        settle();
        chk("clr_ovr", 32'(overrun), 32'd0);

        // Random traffic with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                @(negedge clk); #1 rst = 1'b1;
                @(negedge clk); #1 rst = 1'b0;
            end
            cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
        end
        cyc(0, 8'h00, 0, 0, 0, 0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
